alu_bus_capture: RTL and testbench

Receiving end of the shared ALU output bus. Each functional unit, such as the adder, drives result[7:0] and flags[2:0] onto the bus while its oe is high. This block samples the bus on the cycle the issue logic marks as valid and updates the architectural status register (carry, negative, zero). It queues each result with its destination register in a 2-entry buffer and hands it to register-file writeback with a valid/ready handshake.

---
 rtl/alu_bus_capture_if.sv | 28 ++
 rtl/alu_bus_capture.sv | 65 ++++++
 tb/tb_alu_bus_capture.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_bus_capture_if.sv
// alu_bus_capture_if: ALU result bus, status control and writeback handshake
interface alu_bus_capture_if #(parameter int DEST_W = 3);
  logic              bus_valid;
  logic [7:0]        alu_result;
  logic [2:0]        alu_flags;
  logic              flag_we;
  logic [DEST_W-1:0] dest;
  logic              status_load;
  logic [2:0]        status_in;
  logic              clr_overrun;
  logic              wb_ready;
  logic              wb_valid;
  logic [7:0]        wb_data;
  logic [DEST_W-1:0] wb_dest;
  logic [2:0]        status;
  logic              full;
  logic              overrun;
  modport slave (
    input  bus_valid, alu_result, alu_flags, flag_we, dest,
    input  status_load, status_in, clr_overrun, wb_ready,
    output wb_valid, wb_data, wb_dest, status, full, overrun
  );
  modport master (
    output bus_valid, alu_result, alu_flags, flag_we, dest,
    output status_load, status_in, clr_overrun, wb_ready,
    input  wb_valid, wb_data, wb_dest, status, full, overrun
  );
endinterface

// File: rtl/alu_bus_capture.sv
// alu_bus_capture: samples the ALU bus into a 2-entry writeback buffer and keeps the C/N/Z status register
module alu_bus_capture #(
  parameter int DEPTH  = 2,
  parameter int DEST_W = 3
) (
  input logic         clock,
  input logic         nreset,
  alu_bus_capture_if.slave bus
);
  localparam logic [1:0] FULL_CNT = 2'(DEPTH);
  logic [7:0]        data_q [DEPTH];
  logic [7:0]        data_d [DEPTH];
  logic [DEST_W-1:0] dest_q [DEPTH];
  logic [DEST_W-1:0] dest_d [DEPTH];
  logic              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]        count_q, count_d;
  logic [2:0]        status_q, status_d;
  logic              overrun_q, overrun_d;
  logic              push, pop, drop;
  always_comb begin
    push      = bus.bus_valid && (count_q != FULL_CNT || bus.wb_ready);
    pop       = (count_q != 2'd0) && bus.wb_ready;
    drop      = bus.bus_valid && !push;
    data_d    = data_q;
    dest_d    = dest_q;
    if (push) begin
      data_d[wptr_q] = bus.alu_result;
      dest_d[wptr_q] = bus.dest;
    end
    wptr_d    = wptr_q ^ push;
    rptr_d    = rptr_q ^ pop;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    // flags follow program order, so a dropped result still updates them
    status_d  = bus.status_load ? bus.status_in :
                (bus.bus_valid && bus.flag_we) ? bus.alu_flags : status_q;
    overrun_d = drop | (overrun_q & ~bus.clr_overrun);
  end
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      data_q    <= '{default: '0};
      dest_q    <= '{default: '0};
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      count_q   <= 2'd0;
      status_q  <= 3'b000;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      dest_q    <= dest_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      status_q  <= status_d;
      overrun_q <= overrun_d;
    end
  end
  always_comb begin
    bus.wb_valid = count_q != 2'd0;
    bus.wb_data  = data_q[rptr_q];
    bus.wb_dest  = dest_q[rptr_q];
    bus.full     = count_q == FULL_CNT;
    bus.status   = status_q;
    bus.overrun  = overrun_q;
  end
endmodule

// File: tb/tb_alu_bus_capture.sv
// tb_alu_bus_capture: scenario tasks with a result scoreboard for alu_bus_capture
module tb_alu_bus_capture;
  logic clock = 1'b0;
  logic nreset;
  int   errors = 0;
  int   checks = 0;
  logic [10:0] exp_q [$];
  logic [2:0]  m_status;
  logic        m_overrun;
  always #5 clock = ~clock;
  alu_bus_capture_if #(.DEST_W(3)) bus ();
  alu_bus_capture #(.DEPTH(2), .DEST_W(3)) dut (.clock(clock), .nreset(nreset), .bus(bus));

  task automatic clk_step();
    bit push, pop, drop;
    pop  = exp_q.size() != 0 && bus.wb_ready;
    push = bus.bus_valid && (exp_q.size() < 2 || bus.wb_ready);
    drop = bus.bus_valid && !push;
    m_overrun = drop ? 1'b1 : bus.clr_overrun ? 1'b0 : m_overrun;
    m_status  = bus.status_load ? bus.status_in : (bus.bus_valid && bus.flag_we) ? bus.alu_flags : m_status;
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back({bus.dest, bus.alu_result});
    @(posedge clock);
    #1;
  endtask

  task automatic capture(input logic [7:0] r, input logic [2:0] f, input logic we, input logic [2:0] d);
    bus.bus_valid = 1'b1; bus.alu_result = r; bus.alu_flags = f; bus.flag_we = we; bus.dest = d;
    clk_step();
    bus.bus_valid = 1'b0; bus.alu_result = 8'hzz; bus.alu_flags = 3'bzzz; bus.flag_we = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.full !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got valid=%b full=%b ovr=%b exp 0 0 0", bus.wb_valid, bus.full, bus.overrun);
    end
    checks++;
    if (bus.status !== 3'b000) begin errors++; $display("FAIL reset_status got=%b exp=000", bus.status); end
    checks++;
    if (bus.wb_data !== 8'h00 || bus.wb_dest !== 3'd0) begin
      errors++; $display("FAIL reset_data got=%h/%0d exp=00/0", bus.wb_data, bus.wb_dest);
    end
  endtask

  task automatic test_single();
    bus.wb_ready = 1'b1;
    capture(8'h5A, 3'b000, 1'b1, 3'd3);
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 8'h5A || bus.wb_data !== exp_q[0][7:0]) begin
      errors++; $display("FAIL single_data got valid=%b data=%h exp 1 5a", bus.wb_valid, bus.wb_data);
    end
    checks++;
    if (bus.wb_dest !== 3'd3 || bus.status !== 3'b000) begin
      errors++; $display("FAIL single_dest got dest=%0d status=%b exp 3 000", bus.wb_dest, bus.status);
    end
    clk_step();
    checks++;
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL single_drain got valid=%b exp=0", bus.wb_valid); end
  endtask

  task automatic test_fill_overrun();
    bus.wb_ready = 1'b0;
    capture(8'h01, 3'b000, 1'b0, 3'd1);
    capture(8'h02, 3'b000, 1'b0, 3'd2);
    checks++;
    if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", bus.full); end
    capture(8'h03, 3'b101, 1'b1, 3'd4);
    checks++;
    if (bus.overrun !== 1'b1 || bus.status !== 3'b101 || bus.full !== 1'b1) begin
      errors++; $display("FAIL fill_overrun got ovr=%b status=%b full=%b exp 1 101 1", bus.overrun, bus.status, bus.full);
    end
    bus.wb_ready = 1'b1;
    checks++;
    if (bus.wb_data !== 8'h01 || bus.wb_data !== exp_q[0][7:0]) begin
      errors++; $display("FAIL fill_pop0 got=%h exp=01", bus.wb_data);
    end
    clk_step();
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 8'h02 || bus.wb_dest !== exp_q[0][10:8]) begin
      errors++; $display("FAIL fill_pop1 got valid=%b data=%h exp 1 02", bus.wb_valid, bus.wb_data);
    end
    clk_step();
    checks++;
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL fill_no03 got valid=%b data=%h exp valid 0", bus.wb_valid, bus.wb_data); end
    bus.clr_overrun = 1'b1;
    clk_step();
    bus.clr_overrun = 1'b0;
    checks++;
    if (bus.overrun !== m_overrun || bus.overrun !== 1'b0) begin
      errors++; $display("FAIL clr_overrun got=%b exp=0", bus.overrun);
    end
  endtask

  task automatic test_full_pop_push();
    bus.wb_ready = 1'b0;
    capture(8'hA0, 3'b000, 1'b0, 3'd5);
    capture(8'hA1, 3'b000, 1'b0, 3'd6);
    bus.wb_ready = 1'b1;
    capture(8'hA2, 3'b000, 1'b0, 3'd7);
    checks++;
    if (bus.overrun !== 1'b0 || bus.full !== 1'b1) begin
      errors++; $display("FAIL pp_full got ovr=%b full=%b exp 0 1", bus.overrun, bus.full);
    end
    checks++;
    if (bus.wb_data !== 8'hA1 || bus.wb_dest !== 3'd6 || bus.wb_data !== exp_q[0][7:0]) begin
      errors++; $display("FAIL pp_head1 got=%h/%0d exp=a1/6", bus.wb_data, bus.wb_dest);
    end
    clk_step();
    checks++;
    if (bus.wb_data !== 8'hA2 || bus.wb_dest !== 3'd7 || bus.full !== 1'b0) begin
      errors++; $display("FAIL pp_head2 got=%h/%0d full=%b exp=a2/7 0", bus.wb_data, bus.wb_dest, bus.full);
    end
    clk_step();
    checks++;
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got valid=%b exp=0", bus.wb_valid); end
  endtask

  task automatic test_status_priority();
    bus.wb_ready = 1'b0;
    bus.status_load = 1'b1; bus.status_in = 3'b010;
    capture(8'h77, 3'b001, 1'b1, 3'd2);
    bus.status_load = 1'b0;
    checks++;
    if (bus.status !== 3'b010 || bus.status !== m_status) begin
      errors++; $display("FAIL prio_status got=%b exp=010", bus.status);
    end
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 8'h77) begin
      errors++; $display("FAIL prio_queued got valid=%b data=%h exp 1 77", bus.wb_valid, bus.wb_data);
    end
  endtask

  task automatic test_flag_we0();
    capture(8'h3C, 3'b111, 1'b0, 3'd1);
    checks++;
    if (bus.status !== 3'b010 || bus.status !== m_status) begin
      errors++; $display("FAIL fwe0_status got=%b exp=010", bus.status);
    end
    checks++;
    if (bus.full !== 1'b1 || exp_q.size() != 2 || exp_q[1][7:0] !== 8'h3C || bus.wb_data !== exp_q[0][7:0]) begin
      errors++; $display("FAIL fwe0_queued got full=%b head=%h exp 1 77", bus.full, bus.wb_data);
    end
  endtask

  task automatic test_async_reset();
    capture(8'hEE, 3'b110, 1'b1, 3'd0);
    checks++;
    if (bus.overrun !== 1'b1 || bus.full !== 1'b1 || bus.status !== 3'b110) begin
      errors++; $display("FAIL ar_pre got ovr=%b full=%b status=%b exp 1 1 110", bus.overrun, bus.full, bus.status);
    end
    #2;
    nreset = 1'b0;
    #1;
    exp_q.delete(); m_status = 3'b000; m_overrun = 1'b0;
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.full !== 1'b0 || bus.status !== 3'b000 || bus.overrun !== 1'b0) begin
      errors++; $display("FAIL ar_async got valid=%b full=%b status=%b ovr=%b exp 0 0 000 0", bus.wb_valid, bus.full, bus.status, bus.overrun);
    end
    #1;
    nreset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL ar_nopulse got valid=%b exp=0", bus.wb_valid); end
  endtask

  task automatic test_back_to_back();
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.bus_valid = 1'b1; bus.alu_result = 8'h10 + 8'(i); bus.dest = 3'(i); bus.flag_we = 1'b1; bus.alu_flags = 3'(i);
      clk_step();
      checks++;
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== 8'h10 + 8'(i) || bus.wb_data !== exp_q[0][7:0] || bus.status !== 3'(i)) begin
        errors++; $display("FAIL b2b_%0d got valid=%b data=%h status=%b exp 1 %h %b", i, bus.wb_valid, bus.wb_data, bus.status, 8'h10 + 8'(i), 3'(i));
      end
    end
    bus.bus_valid = 1'b0; bus.flag_we = 1'b0;
    clk_step();
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_end got valid=%b ovr=%b exp 0 0", bus.wb_valid, bus.overrun);
    end
  endtask

  initial begin
    nreset = 1'b0;
    bus.bus_valid = 1'b0; bus.alu_result = 8'hzz; bus.alu_flags = 3'bzzz; bus.flag_we = 1'b0; bus.dest = 3'd0;
    bus.status_load = 1'b0; bus.status_in = 3'b000; bus.clr_overrun = 1'b0; bus.wb_ready = 1'b0;
    m_status = 3'b000; m_overrun = 1'b0;
    #3;
    test_reset();
    @(posedge clock);
    #1;
    nreset = 1'b1;
    @(posedge clock);
    #1;
    test_single();
    test_fill_overrun();
    test_full_pop_push();
    test_status_priority();
    test_flag_we0();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
